// File: rtl/toplama_seri.sv
// toplama_seri: bit-serial adder, LSB first, one full-adder cell plus a
// carry flip-flop. Produces a 64-bit result word (sum shifted left by FRAC)
// together with the hazir/gecerli/tasma flags. Supports unsigned and
// two's-complement operands.
module toplama_seri #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             basla,
  input  logic             isaretli,
  input  logic [WIDTH-1:0] sayi1,
  input  logic [WIDTH-1:0] sayi2,
  output logic [63:0]      sonuc,
  output logic             hazir,
  output logic             gecerli,
  output logic             tasma
);

  // One extra counter bit, so the count can never wrap within one operation.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    HESAP = 2'd1,
    BITTI = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cmsb_q, cmsb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [63:0]      sonuc_q, sonuc_d;
  logic             tasma_q, tasma_d;
  logic             gecerli_q, gecerli_d;

  logic [CW-2:0]    idx;
  logic             fa_a, fa_b, fa_s, fa_c;
  logic             top_bit;
  logic             fill_bit;
  logic [63:0]      ext;

  // The full-adder cell acts on bit k of each operand and the running carry.
  assign idx  = cnt_q[CW-2:0];
  assign fa_a = a_q[idx];
  assign fa_b = b_q[idx];
  assign fa_s = fa_a ^ fa_b ^ c_q;
  assign fa_c = (fa_a & fa_b) | (fa_a & c_q) | (fa_b & c_q);

  // Bit WIDTH of the (WIDTH+1)-bit result. Unsigned: the carry-out.
  // Signed: the true sign, recomputed from the operand MSBs and the carry-out.
  assign top_bit  = sgn_q ? (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ c_q) : c_q;
  assign fill_bit = sgn_q & top_bit;

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_ext
      if (gi < WIDTH) begin : g_sum
        assign ext[gi] = sum_q[gi];
      end else if (gi == WIDTH) begin : g_top
        assign ext[gi] = top_bit;
      end else begin : g_fill
        assign ext[gi] = fill_bit;
      end
    end
  endgenerate

  // Next-state and datapath logic for the BOSTA -> HESAP -> BITTI sequence.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    sum_d     = sum_q;
    c_d       = c_q;
    cmsb_d    = cmsb_q;
    cnt_d     = cnt_q;
    sonuc_d   = sonuc_q;
    tasma_d   = tasma_q;
    gecerli_d = gecerli_q;
    case (state_q)
      BOSTA: begin
        if (basla) begin
          a_d       = sayi1;
          b_d       = sayi2;
          sgn_d     = isaretli;
          sum_d     = '0;
          c_d       = 1'b0;
          cnt_d     = '0;
          gecerli_d = 1'b0;
          state_d   = HESAP;
        end
      end
      HESAP: begin
        sum_d[idx] = fa_s;
        c_d        = fa_c;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // The carry entering the MSB is needed for signed overflow.
          cmsb_d  = c_q;
          state_d = BITTI;
        end
      end
      BITTI: begin
        sonuc_d   = ext << FRAC;
        tasma_d   = sgn_q ? (c_q ^ cmsb_q) : c_q;
        gecerli_d = 1'b1;
        state_d   = BOSTA;
      end
      default: state_d = BOSTA;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOSTA;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      sum_q     <= '0;
      c_q       <= 1'b0;
      cmsb_q    <= 1'b0;
      cnt_q     <= '0;
      sonuc_q   <= '0;
      tasma_q   <= 1'b0;
      gecerli_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      sum_q     <= sum_d;
      c_q       <= c_d;
      cmsb_q    <= cmsb_d;
      cnt_q     <= cnt_d;
      sonuc_q   <= sonuc_d;
      tasma_q   <= tasma_d;
      gecerli_q <= gecerli_d;
    end
  end

  assign hazir   = (state_q == BOSTA);
  assign gecerli = gecerli_q;
  assign tasma   = tasma_q;
  assign sonuc   = sonuc_q;

endmodule

// File: tb/tb_toplama_seri.sv
// Directed bench for toplama_seri: reset, unsigned/signed sums, overflow,
// busy-ignore, mid-operation reset and back-to-back operation.
module tb_toplama_seri;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;

  logic             clk;
  logic             rst_n;
  logic             basla;
  logic             isaretli;
  logic [WIDTH-1:0] sayi1;
  logic [WIDTH-1:0] sayi2;
  logic [63:0]      sonuc;
  logic             hazir;
  logic             gecerli;
  logic             tasma;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  toplama_seri #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .basla    (basla),
    .isaretli (isaretli),
    .sayi1    (sayi1),
    .sayi2    (sayi2),
    .sonuc    (sonuc),
    .hazir    (hazir),
    .gecerli  (gecerli),
    .tasma    (tasma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; basla is high across exactly one rising edge.
  task automatic start(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    isaretli = s;
    sayi1    = x;
    sayi2    = y;
    basla    = 1'b1;
    @(negedge clk);
    basla    = 1'b0;
  endtask

  // Counts falling edges that see hazir=0, bounded so a stuck DUT still ends.
  task automatic wait_done(output int n);
    n = 0;
    while (hazir !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    basla    = 1'b0;
    isaretli = 1'b0;
    sayi1    = '0;
    sayi2    = '0;
    repeat (2) @(negedge clk);
    chk("rst_hazir",   64'(hazir),   64'd1);
    chk("rst_gecerli", 64'(gecerli), 64'd0);
    chk("rst_tasma",   64'(tasma),   64'd0);
    chk("rst_sonuc",   sonuc,        64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned 5+3 with latency check
    start(1'b0, 32'd5, 32'd3);
    chk("u53_busy", 64'(hazir), 64'd0);
    wait_done(lat);
    chk("u53_latency", 64'(lat),     64'(WIDTH + 1));
    chk("u53_sonuc",   sonuc,        64'h0000_0000_0008_0000);
    chk("u53_tasma",   64'(tasma),   64'd0);
    chk("u53_gecerli", 64'(gecerli), 64'd1);
    chk("u53_hazir",   64'(hazir),   64'd1);

    // Reset in the middle of an operation
    start(1'b0, 32'h0000_0010, 32'h0000_0020);
    chk("mid_gecerli_drop", 64'(gecerli), 64'd0);
    chk("mid_sonuc_held",   sonuc,        64'h0000_0000_0008_0000);
    repeat (5) @(negedge clk);
    chk("mid_busy", 64'(hazir), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_hazir",   64'(hazir),   64'd1);
    chk("mid_rst_gecerli", 64'(gecerli), 64'd0);
    chk("mid_rst_sonuc",   sonuc,        64'd0);
    chk("mid_rst_tasma",   64'(tasma),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned overflow
    start(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done(lat);
    chk("uovf_latency", 64'(lat),     64'(WIDTH + 1));
    chk("uovf_sonuc",   sonuc,        64'h0001_0000_0000_0000);
    chk("uovf_tasma",   64'(tasma),   64'd1);
    chk("uovf_gecerli", 64'(gecerli), 64'd1);

    // Signed overflow, with an ignored basla pulse while busy
    start(1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
    repeat (3) @(negedge clk);
    start(1'b0, 32'd5, 32'd3);
    wait_done(lat);
    chk("sovf_latency", 64'(lat),     64'(WIDTH + 1 - 4));
    chk("sovf_sonuc",   sonuc,        64'h0000_8000_0000_0000);
    chk("sovf_tasma",   64'(tasma),   64'd1);
    repeat (2) @(negedge clk);
    chk("busy_ignored_hazir",  64'(hazir), 64'd1);
    chk("busy_ignored_sonuc",  sonuc,      64'h0000_8000_0000_0000);

    // Signed -2+1, then back-to-back with basla held high
    isaretli = 1'b1;
    sayi1    = 32'hFFFF_FFFE;
    sayi2    = 32'h0000_0001;
    basla    = 1'b1;
    @(negedge clk);
    wait_done(lat);
    chk("sneg_latency", 64'(lat),     64'(WIDTH + 1));
    chk("sneg_sonuc",   sonuc,        64'hFFFF_FFFF_FFFF_0000);
    chk("sneg_tasma",   64'(tasma),   64'd0);
    chk("sneg_gecerli", 64'(gecerli), 64'd1);
    isaretli = 1'b0;
    sayi1    = 32'hFFFF_FFFF;
    sayi2    = 32'h0000_0001;
    @(negedge clk);
    basla = 1'b0;
    chk("b2b_restart_hazir", 64'(hazir),   64'd0);
    chk("b2b_gecerli_drop",  64'(gecerli), 64'd0);
    chk("b2b_sonuc_held",    sonuc,        64'hFFFF_FFFF_FFFF_0000);
    wait_done(lat);
    chk("b2b_latency", 64'(lat),     64'(WIDTH + 1));
    chk("b2b_sonuc",   sonuc,        64'h0001_0000_0000_0000);
    chk("b2b_tasma",   64'(tasma),   64'd1);
    chk("b2b_gecerli", 64'(gecerli), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/toplama_seri.md
Name: toplama_seri

Overview:
Bit-serial adder for the calculator datapath. It computes the sum of two operands one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. It is the addition counterpart of the existing serial subtraction unit. It drives the same output word format and the same hazir/gecerli/tasma result flags, and adds an explicit start handshake, signed/unsigned mode and asynchronous reset.

Parameters:
WIDTH, 32, operand width in bits.
FRAC, 16, left shift applied to the result inside the 64-bit sonuc word. Constraint: WIDTH+1+FRAC <= 64.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
basla  input  1  start request; accepted only when hazir=1.
isaretli  input  1  operand mode; 1 = two's-complement, 0 = unsigned; sampled with the operands.
sayi1  input  WIDTH  first operand; sampled on acceptance.
sayi2  input  WIDTH  second operand; sampled on acceptance.
sonuc  output  64  formatted result; held stable until the next accepted start.
hazir  output  1  unit idle and able to accept basla.
gecerli  output  1  sonuc/tasma hold the result of the last completed operation.
tasma  output  1  overflow flag for the last completed operation.

Behaviour:
- Reset (rst_n=0, asynchronous): state BOSTA, hazir=1, gecerli=0, tasma=0, sonuc=0. Operand, sum, carry and bit-counter registers are cleared. Reset asserted mid-computation aborts the operation; no partial result is ever flagged valid.
- FSM states:
  - BOSTA: idle, hazir=1.
  - HESAP: computing, hazir=0.
  - BITTI: one formatting cycle, hazir=0.
- Acceptance: on a rising edge with state BOSTA and basla=1:
  - latch sayi1, sayi2, isaretli;
  - clear the carry, sum register and counter;
  - set gecerli=0 and go to HESAP.
  - sonuc and tasma keep their old values until completion.
- HESAP: on each edge, with k = counter:
  - sum[k] = a[k] ^ b[k] ^ c;
  - c <= majority(a[k], b[k], c);
  - counter increments.
  - The edge that processes k=WIDTH-1 moves to BITTI, retaining the final carry-out (cout) and the carry into the MSB (cmsb).
- BITTI (one edge): load the outputs, set hazir=1 and gecerli=1, return to BOSTA.
  - Unsigned: sonuc = {zeros, cout, sum[WIDTH-1:0], FRAC zeros}; tasma = cout.
  - Signed: s = {a[WIDTH-1]^b[WIDTH-1]^cout, sum}, i.e. the true (WIDTH+1)-bit sum. sonuc = sign-extension of s to 64-FRAC bits, followed by FRAC zeros. tasma = cout ^ cmsb.
- Latency: acceptance at edge T. The result is visible, with hazir=gecerli=1, after edge T+WIDTH+1. Back-to-back operation is possible: basla held high is re-accepted on the edge after hazir returns, so throughput is one result per WIDTH+2 cycles.
- basla while hazir=0 is ignored; operand or mode changes during HESAP/BITTI have no effect.
- gecerli stays 1 until the next accepted start, then drops on that acceptance edge.
- Counter width is clog2(WIDTH)+1; no wrap-around is possible within one operation.

Test Plan:
- Reset mid-operation: assert rst_n=0 during HESAP -> immediately hazir=1, gecerli=0, sonuc=0, tasma=0. After release, the next operation is correct.
- Unsigned 5+3 -> after WIDTH+1 edges: sonuc=0x0000_0000_0008_0000, tasma=0, gecerli=1, hazir=1. hazir must be 0 for exactly WIDTH+1 cycles.
- Unsigned 0xFFFF_FFFF+0x0000_0001 -> sonuc=0x0001_0000_0000_0000, tasma=1.
- Signed 0x7FFF_FFFF+0x0000_0001 -> sonuc=0x0000_8000_0000_0000, tasma=1.
- Signed 0xFFFF_FFFE+0x0000_0001 -> sonuc=0xFFFF_FFFF_FFFF_0000, tasma=0.
- Busy/back-to-back: pulse basla with new operands during HESAP -> ignored, first result unchanged. Hold basla=1 continuously -> a second operation starts on the edge after hazir rises, and gecerli drops on that same edge.
